hex_display_mux: RTL and testbench

Parametrised multiplexed 7-segment driver, the successor of the fixed 4-digit scanner. Supports N digits, per-digit decimal points and blanking, and PWM brightness with anti-ghosting dead time. Display words are loaded through a valid/ready handshake and applied only at frame boundaries, so the display never tears. Sits between CPU/MMIO register logic and board anode/segment pins.

---
 rtl/hex_display_pkg.sv | 59 +++++
 rtl/seg7_decode.sv | 13 +
 rtl/hex_display_mux.sv | 191 +++++++++++++++++++
 tb/tb_hex_display_mux.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared 7-segment definitions: segment vector type, bit positions, hex glyphs.
// Bit positions use a SEG_BIT_ prefix so they cannot collide with the SEG_A..SEG_F glyphs.
package hex_display_pkg;

    typedef logic [7:0] seg_t;

    localparam int unsigned SEG_BIT_A = 7;
    localparam int unsigned SEG_BIT_B = 6;
    localparam int unsigned SEG_BIT_C = 5;
    localparam int unsigned SEG_BIT_D = 4;
    localparam int unsigned SEG_BIT_E = 3;
    localparam int unsigned SEG_BIT_F = 2;
    localparam int unsigned SEG_BIT_G = 1;
    localparam int unsigned SEG_BIT_P = 0;

    localparam seg_t SEG_OFF = 8'b0000_0000;

    // Glyphs as {A,B,C,D,E,F,G,P} with the decimal point clear
    localparam seg_t SEG_0 = 8'b1111_1100;
    localparam seg_t SEG_1 = 8'b0110_0000;
    localparam seg_t SEG_2 = 8'b1101_1010;
    localparam seg_t SEG_3 = 8'b1111_0010;
    localparam seg_t SEG_4 = 8'b0110_0110;
    localparam seg_t SEG_5 = 8'b1011_0110;
    localparam seg_t SEG_6 = 8'b1011_1110;
    localparam seg_t SEG_7 = 8'b1110_0000;
    localparam seg_t SEG_8 = 8'b1111_1110;
    localparam seg_t SEG_9 = 8'b1111_0110;
    localparam seg_t SEG_A = 8'b1110_1110;
    localparam seg_t SEG_B = 8'b0011_1110;
    localparam seg_t SEG_C = 8'b1001_1100;
    localparam seg_t SEG_D = 8'b0111_1010;
    localparam seg_t SEG_E = 8'b1001_1110;
    localparam seg_t SEG_F = 8'b1000_1110;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        seg_t g;
        unique case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
        endcase
        return g[SEG_BIT_A -: 7];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to ABCDEFG segment pattern (A in bit 6).
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_c_o
);

    always_comb begin
        glyph_c_o = hex_glyph(nibble_i);
    end

endmodule

// File: rtl/hex_display_mux.sv
// N-digit multiplexed 7-segment driver with PWM brightness, dead time and frame-aligned loads.
// Optional leading-zero suppression when HEX_DISPLAY_LZ_BLANK_EN is defined.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned CNT_WIDTH   = 14,
    parameter int unsigned BRIGHT_W    = 4,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dots,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic [BRIGHT_W-1:0]   i_bright,
    output logic [DIGITS-1:0]     o_anodes,
    output logic [7:0]            o_segments,
    output logic                  o_frame
);

    localparam int unsigned POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(DIGITS - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 frame_q;
    logic                 boundary_c;

    logic                 pend_full_q, pend_full_d;
    logic [4*DIGITS-1:0]  pend_data_q, pend_data_d;
    logic [DIGITS-1:0]    pend_dots_q, pend_dots_d;
    logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
    logic [BRIGHT_W-1:0]  pend_bright_q, pend_bright_d;

    logic [4*DIGITS-1:0]  act_data_q, act_data_d;
    logic [DIGITS-1:0]    act_dots_q, act_dots_d;
    logic [DIGITS-1:0]    act_blank_q, act_blank_d;
    logic [BRIGHT_W-1:0]  act_bright_q, act_bright_d;

    logic [DIGITS-1:0]    anodes_q, anodes_d;
    seg_t                 segs_q, segs_d;

    logic                 accept_c;
    logic [DIGITS-1:0]    lz_c;
    logic [DIGITS-1:0]    dark_c;
    logic [3:0]           nib_c;
    logic                 dot_c;
    logic                 dark_sel_c;
    logic [BRIGHT_W-1:0]  phase_c;
    logic                 en_c;
    logic [6:0]           glyph_c;

    // Slot counter and digit position
    always_comb begin
        cnt_d      = cnt_q + CNT_WIDTH'(1);
        pos_d      = pos_q;
        boundary_c = (pos_q == POS_LAST) && (cnt_q == CNT_MAX);
        if (cnt_q == CNT_MAX) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end
    end

    // Load handshake: pending buffer drains into active only on the frame boundary
    always_comb begin
        accept_c      = i_valid && !pend_full_q;
        pend_full_d   = pend_full_q;
        pend_data_d   = pend_data_q;
        pend_dots_d   = pend_dots_q;
        pend_blank_d  = pend_blank_q;
        pend_bright_d = pend_bright_q;
        act_data_d    = act_data_q;
        act_dots_d    = act_dots_q;
        act_blank_d   = act_blank_q;
        act_bright_d  = act_bright_q;
        if (boundary_c) begin
            if (pend_full_q) begin
                act_data_d   = pend_data_q;
                act_dots_d   = pend_dots_q;
                act_blank_d  = pend_blank_q;
                act_bright_d = pend_bright_q;
                pend_full_d  = 1'b0;
            end else if (accept_c) begin
                act_data_d   = i_data;
                act_dots_d   = i_dots;
                act_blank_d  = i_blank;
                act_bright_d = i_bright;
            end
        end else if (accept_c) begin
            pend_data_d   = i_data;
            pend_dots_d   = i_dots;
            pend_blank_d  = i_blank;
            pend_bright_d = i_bright;
            pend_full_d   = 1'b1;
        end
    end

`ifdef HEX_DISPLAY_LZ_BLANK_EN
    logic zero_run_c;

    // Blank zeros from the top digit down to the first non-zero; digit 0 always shows
    always_comb begin
        lz_c       = '0;
        zero_run_c = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run_c = zero_run_c && (act_data_q[4*k +: 4] == 4'h0);
            lz_c[k]    = zero_run_c;
        end
    end
`else
    always_comb begin
        lz_c = '0;
    end
`endif

    // Select the current digit's nibble, dot and dark flag
    always_comb begin
        dark_c     = act_blank_q | lz_c;
        nib_c      = 4'h0;
        dot_c      = 1'b0;
        dark_sel_c = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (pos_q == POS_W'(k)) begin
                nib_c      = act_data_q[4*k +: 4];
                dot_c      = act_dots_q[k];
                dark_sel_c = dark_c[k];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .nibble_i  (nib_c),
        .glyph_c_o (glyph_c)
    );

    // Digit enable: past dead time, inside PWM on-window, not blanked
    always_comb begin
        phase_c  = cnt_q[CNT_WIDTH-1 -: BRIGHT_W];
        en_c     = (cnt_q >= CNT_WIDTH'(DEAD_CYCLES)) && (phase_c < act_bright_q) && !dark_sel_c;
        anodes_d = '1;
        segs_d   = SEG_OFF;
        if (en_c) begin
            anodes_d          = ~(DIGITS'(1) << pos_q);
            segs_d            = {glyph_c, 1'b0};
            segs_d[SEG_BIT_P] = dot_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            pos_q         <= '0;
            frame_q       <= 1'b0;
            pend_full_q   <= 1'b0;
            pend_data_q   <= '0;
            pend_dots_q   <= '0;
            pend_blank_q  <= '0;
            pend_bright_q <= '0;
            act_data_q    <= '0;
            act_dots_q    <= '0;
            act_blank_q   <= '0;
            act_bright_q  <= '0;
            anodes_q      <= '1;
            segs_q        <= SEG_OFF;
        end else begin
            cnt_q         <= cnt_d;
            pos_q         <= pos_d;
            frame_q       <= boundary_c;
            pend_full_q   <= pend_full_d;
            pend_data_q   <= pend_data_d;
            pend_dots_q   <= pend_dots_d;
            pend_blank_q  <= pend_blank_d;
            pend_bright_q <= pend_bright_d;
            act_data_q    <= act_data_d;
            act_dots_q    <= act_dots_d;
            act_blank_q   <= act_blank_d;
            act_bright_q  <= act_bright_d;
            anodes_q      <= anodes_d;
            segs_q        <= segs_d;
        end
    end

    assign o_ready    = !pend_full_q;
    assign o_anodes   = anodes_q;
    assign o_segments = segs_q;
    assign o_frame    = frame_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux (4 digits, 64-clock slots, 2-bit brightness, 2 dead cycles).
module tb_hex_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_data = '0;
    logic [3:0]  i_dots = '0;
    logic [3:0]  i_blank = '0;
    logic [1:0]  i_bright = '0;
    logic [3:0]  o_anodes;
    logic [7:0]  o_segments;
    logic        o_frame;

    int checks = 0;
    int errors = 0;

    hex_display_mux #(
        .DIGITS      (4),
        .CNT_WIDTH   (6),
        .BRIGHT_W    (2),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_dots     (i_dots),
        .i_blank    (i_blank),
        .i_bright   (i_bright),
        .o_anodes   (o_anodes),
        .o_segments (o_segments),
        .o_frame    (o_frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next o_frame pulse (sample point where pos==0, cnt==0)
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_frame && n < 400);
        chk("frame_wait", 32'(o_frame), 32'd1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dots,
                        input logic [3:0] blank, input logic [1:0] br);
        int n;
        i_data   = d;
        i_dots   = dots;
        i_blank  = blank;
        i_bright = br;
        i_valid  = 1'b1;
        n = 0;
        while (!o_ready && n < 400) begin
            step();
            n++;
        end
        chk("load_ready", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
    endtask

    // Sample s (1..256) after a frame pulse shows slot (s-1)/64 at cnt (s-1)%64
    task automatic check_frame(input string tag, input logic [3:0][7:0] segs,
                               input logic [3:0] blank, input int bright, input int first_s);
        for (int s = first_s; s <= 256; s++) begin
            int  slot;
            int  c;
            bit  lit;
            logic [3:0] exp_an;
            logic [7:0] exp_seg;
            step();
            slot    = (s - 1) / 64;
            c       = (s - 1) % 64;
            lit     = (c >= 2) && ((c / 16) < bright) && !blank[slot];
            exp_an  = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? segs[slot] : 8'h00;
            chk($sformatf("%s_anodes_s%0d", tag, s), 32'(o_anodes), 32'(exp_an));
            chk($sformatf("%s_segments_s%0d", tag, s), 32'(o_segments), 32'(exp_seg));
            if (s == 128) chk($sformatf("%s_frame_mid", tag), 32'(o_frame), 32'd0);
            if (s == 256) chk($sformatf("%s_frame_end", tag), 32'(o_frame), 32'd1);
        end
    endtask

    logic [3:0][7:0] segs_1234;
    logic [3:0][7:0] segs_1234_dot;
    logic [3:0][7:0] segs_0050;
    logic [3:0][7:0] segs_abcd;
    logic [3:0][7:0] segs_5678;
    logic [3:0][7:0] segs_ef09;
    logic [3:0]      lz_blank_0050;

    initial begin
        segs_1234     = {8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110};
        segs_1234_dot = {8'b01100000, 8'b11011011, 8'b11110010, 8'b01100110};
        segs_0050     = {8'b11111100, 8'b11111100, 8'b10110110, 8'b11111100};
        segs_abcd     = {8'b11101110, 8'b00111110, 8'b10011100, 8'b01111010};
        segs_5678     = {8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110};
        segs_ef09     = {8'b10011110, 8'b10001110, 8'b11111100, 8'b11110110};
`ifdef HEX_DISPLAY_LZ_BLANK_EN
        lz_blank_0050 = 4'b1100;
`else
        lz_blank_0050 = 4'b0000;
`endif

        // Reset values
        step();
        step();
        chk("rst_anodes", 32'(o_anodes), 32'hF);
        chk("rst_segments", 32'(o_segments), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_frame", 32'(o_frame), 32'd0);
        rst = 1'b0;

        // Basic display of 1234 at full brightness
        wait_frame();
        check_frame("dark0", segs_1234, 4'h0, 0, 1);
        load(16'h1234, 4'b0000, 4'b0000, 2'd3);
        wait_frame();
        check_frame("d1234", segs_1234, 4'h0, 3, 1);

        // Decimal point on digit 2, digit 0 blanked
        load(16'h1234, 4'b0100, 4'b0001, 2'd3);
        wait_frame();
        check_frame("dots", segs_1234_dot, 4'b0001, 3, 1);

        // Brightness 0 and 1
        load(16'h1234, 4'b0000, 4'b0000, 2'd0);
        wait_frame();
        check_frame("br0", segs_1234, 4'h0, 0, 1);
        load(16'h1234, 4'b0000, 4'b0000, 2'd1);
        wait_frame();
        check_frame("br1", segs_1234, 4'h0, 1, 1);

        // Leading zeros
        load(16'h0050, 4'b0000, 4'b0000, 2'd3);
        wait_frame();
        check_frame("d0050", segs_0050, lz_blank_0050, 3, 1);

        // Back-to-back loads at a frame sample point: A accepted into pending
        i_data   = 16'hABCD;
        i_dots   = 4'b0000;
        i_blank  = 4'b0000;
        i_bright = 2'd3;
        i_valid  = 1'b1;
        chk("hs_ready_a", 32'(o_ready), 32'd1);
        step();
        chk("hs_busy_a", 32'(o_ready), 32'd0);
        i_data   = 16'h5678;
        i_bright = 2'd2;
        step();
        chk("hs_held_b", 32'(o_ready), 32'd0);
        begin
            int n;
            n = 0;
            while (!o_ready && n < 400) begin
                step();
                n++;
            end
        end
        chk("hs_ready_at_frame", 32'(o_frame), 32'd1);
        chk("hs_ready_b", 32'(o_ready), 32'd1);
        step();
        chk("hs_busy_b", 32'(o_ready), 32'd0);
        // C stays requested through the A frame and must not overwrite pending B
        i_data   = 16'hEF09;
        i_bright = 2'd3;
        check_frame("wordA", segs_abcd, 4'h0, 3, 2);
        chk("hs_ready_c", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        chk("hs_busy_c", 32'(o_ready), 32'd0);
        check_frame("wordB", segs_5678, 4'h0, 2, 2);
        check_frame("wordC", segs_ef09, 4'h0, 3, 1);

        // Reset mid-scan with a word pending
        load(16'h1111, 4'b0000, 4'b0000, 2'd3);
        for (int i = 0; i < 20; i++) step();
        chk("pre_rst_anodes", 32'(o_anodes), 32'hE);
        chk("pre_rst_segments", 32'(o_segments), 32'(8'b11110110));
        chk("pre_rst_ready", 32'(o_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_anodes", 32'(o_anodes), 32'hF);
        chk("mid_rst_segments", 32'(o_segments), 32'h0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_frame", 32'(o_frame), 32'd0);
        step();
        step();
        rst = 1'b0;
        wait_frame();
        check_frame("post_rst0", segs_1234, 4'h0, 0, 1);
        check_frame("post_rst1", segs_1234, 4'h0, 0, 1);
        check_frame("post_rst2", segs_1234, 4'h0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
